bus_xbar: RTL and testbench

//  Pipelined, parametrised N-input x M-output crossbar; successor to the single-select bus mux.

---
 rtl/bus_xbar_if.sv | 30 +++
 rtl/bus_xbar.sv | 126 ++++++++++++
 tb/tb_bus_xbar.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_xbar_if.sv
// Bus bundle for bus_xbar: beat input, select config port, routed output.
// master drives beats/config (upstream side), slave is the crossbar itself.
interface bus_xbar_if #(
    parameter int NUM_INPUT   = 8,
    parameter int NUM_OUTPUT  = 8,
    parameter int SEL_BIT     = 3,
    parameter int OUT_IDX_BIT = 3,
    parameter int DATA_WIDTH  = 8
);
    logic                             in_valid;
    logic [NUM_INPUT*DATA_WIDTH-1:0]  data_in;
    logic                             cfg_we;
    logic [OUT_IDX_BIT-1:0]           cfg_addr;
    logic [SEL_BIT-1:0]               cfg_sel;
    logic                             cfg_commit;
    logic                             err_clr;
    logic                             out_valid;
    logic [NUM_OUTPUT*DATA_WIDTH-1:0] data_out;
    logic                             sel_err;

    modport master (
        output in_valid, data_in, cfg_we, cfg_addr, cfg_sel, cfg_commit, err_clr,
        input  out_valid, data_out, sel_err
    );

    modport slave (
        input  in_valid, data_in, cfg_we, cfg_addr, cfg_sel, cfg_commit, err_clr,
        output out_valid, data_out, sel_err
    );
endinterface

// File: rtl/bus_xbar.sv
// bus_xbar: 3-stage N-in x M-out crossbar with per-output select registers.
// S1 captures lanes + select snapshot, S2 muxes per output lane, S3 holds outputs.
// Optional macro XBAR_SHADOW_EN adds a shadow select bank committed by cfg_commit.
module bus_xbar #(
    parameter int NUM_INPUT   = 8,
    parameter int NUM_OUTPUT  = 8,
    parameter int SEL_BIT     = 3,
    parameter int OUT_IDX_BIT = 3,
    parameter int DATA_WIDTH  = 8
) (
    input  logic      clk,
    input  logic      rst,
    bus_xbar_if.slave bus
);
    localparam int STAGES = 3;
    localparam logic [SEL_BIT:0] NIN = (SEL_BIT+1)'(NUM_INPUT);

    typedef logic [NUM_OUTPUT-1:0][SEL_BIT-1:0] sel_bank_t;

    sel_bank_t                            sel_act, sel_wr, sel_s1;
    logic [NUM_INPUT-1:0][DATA_WIDTH-1:0] data_s1;
    logic [NUM_OUTPUT-1:0][DATA_WIDTH-1:0] mux_c, mux_s2, data_s3;
    logic [NUM_OUTPUT-1:0]                ill_c;
    logic                                 err_s2;
    logic                                 sel_err_q;
    logic [STAGES-1:0]                    vld_pipe;

    // Reset mapping: output k listens to input k mod NUM_INPUT.
    function automatic sel_bank_t identity();
        sel_bank_t r;
        for (int k = 0; k < NUM_OUTPUT; k++) r[k] = SEL_BIT'(k % NUM_INPUT);
        return r;
    endfunction

`ifdef XBAR_SHADOW_EN
    sel_bank_t sel_shd;

    // Merge this cycle's write into the shadow bank; out-of-range addresses match nothing.
    always_comb begin
        sel_wr = sel_shd;
        for (int k = 0; k < NUM_OUTPUT; k++)
            if (bus.cfg_we && bus.cfg_addr == OUT_IDX_BIT'(k)) sel_wr[k] = bus.cfg_sel;
    end

    // Shadow takes every write; active bank switches all lanes together on commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_shd <= identity();
            sel_act <= identity();
        end else begin
            sel_shd <= sel_wr;
            if (bus.cfg_commit) sel_act <= sel_wr;
        end
    end
`else
    logic unused_commit;
    assign unused_commit = bus.cfg_commit;

    // Direct write into the active bank; out-of-range addresses match nothing.
    always_comb begin
        sel_wr = sel_act;
        for (int k = 0; k < NUM_OUTPUT; k++)
            if (bus.cfg_we && bus.cfg_addr == OUT_IDX_BIT'(k)) sel_wr[k] = bus.cfg_sel;
    end

    // Active select bank register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sel_act <= identity();
        else     sel_act <= sel_wr;
    end
`endif

    // Beat valid shift register: [0]=S1, [1]=S2, [2]=S3/out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-2:0], bus.in_valid};
    end

    // S1: raw lanes plus the pre-update select snapshot, so a same-cycle write is not seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_s1 <= '0;
            sel_s1  <= '0;
        end else begin
            data_s1 <= bus.data_in;
            sel_s1  <= sel_act;
        end
    end

    // Per-lane mux; illegal codes yield zero and flag the lane.
    always_comb begin
        mux_c = '0;
        ill_c = '0;
        for (int k = 0; k < NUM_OUTPUT; k++) begin
            if ({1'b0, sel_s1[k]} < NIN) mux_c[k] = data_s1[sel_s1[k]];
            else                         ill_c[k] = 1'b1;
        end
    end

    // S2: registered mux result; error only counts for a real beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mux_s2 <= '0;
            err_s2 <= 1'b0;
        end else begin
            mux_s2 <= mux_c;
            err_s2 <= vld_pipe[0] & (|ill_c);
        end
    end

    // S3: outputs hold between beats; a new error wins over err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_s3   <= '0;
            sel_err_q <= 1'b0;
        end else begin
            if (vld_pipe[1]) data_s3 <= mux_s2;
            if (vld_pipe[1] && err_s2) sel_err_q <= 1'b1;
            else if (bus.err_clr)      sel_err_q <= 1'b0;
        end
    end

    assign bus.out_valid = vld_pipe[STAGES-1];
    assign bus.data_out  = data_s3;
    assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_bus_xbar.sv
// Scoreboard bench for bus_xbar (6 inputs, 8 outputs, 4-bit cfg_addr).
// Stimulus pushes expected beats; a negedge monitor pops and compares on out_valid.
module tb_bus_xbar;
    localparam int NI = 6, NO = 8, SB = 3, OB = 4, DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_xbar_if #(.NUM_INPUT(NI), .NUM_OUTPUT(NO), .SEL_BIT(SB), .OUT_IDX_BIT(OB), .DATA_WIDTH(DW)) bus ();
    bus_xbar #(.NUM_INPUT(NI), .NUM_OUTPUT(NO), .SEL_BIT(SB), .OUT_IDX_BIT(OB), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct { logic [NO*DW-1:0] data; int cyc; } exp_t;
    exp_t q[$];
    int n_checks = 0, n_fail = 0, cyc = 0;
    int act[NO];
    int shd[NO];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [NI*DW-1:0] pat(logic [7:0] b);
        logic [NI*DW-1:0] r;
        for (int i = 0; i < NI; i++) r[i*DW +: DW] = b + 8'(i);
        return r;
    endfunction

    function automatic logic [NO*DW-1:0] route(logic [NI*DW-1:0] d);
        logic [NO*DW-1:0] r;
        r = '0;
        for (int k = 0; k < NO; k++)
            if (act[k] < NI) r[k*DW +: DW] = d[act[k]*DW +: DW];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NO; k++) begin
            act[k] = k % NI;
            shd[k] = k % NI;
        end
    endtask

    // One clock of stimulus; expected beat uses the select bank before this cycle's config.
    task automatic cycle(bit v, logic [NI*DW-1:0] d, bit we = 0, logic [OB-1:0] a = '0,
                         logic [SB-1:0] s = '0, bit cm = 0, bit clr = 0);
        exp_t e;
        if (v) begin
            e.data = route(d);
            e.cyc  = cyc;
            q.push_back(e);
        end
`ifdef XBAR_SHADOW_EN
        if (we && int'(a) < NO) shd[a] = int'(s);
        if (cm) for (int k = 0; k < NO; k++) act[k] = shd[k];
`else
        if (we && int'(a) < NO) act[a] = int'(s);
`endif
        bus.in_valid = v; bus.data_in = d; bus.cfg_we = we; bus.cfg_addr = a;
        bus.cfg_sel = s; bus.cfg_commit = cm; bus.err_clr = clr;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.cfg_we = 1'b0; bus.cfg_commit = 1'b0; bus.err_clr = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) cycle(0, '0);
    endtask

    // Monitor: every presented beat must match the oldest expectation, 3 cycles after issue.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.out_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got data %h with nothing expected", bus.data_out);
            end else begin
                e = q.pop_front();
                chk("beat_data", bus.data_out, e.data);
                chk("beat_latency", 64'(cyc - e.cyc), 64'd3);
            end
        end
    end

    initial begin
        logic [NI*DW-1:0] d;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.data_in = '0; bus.cfg_we = 1'b0; bus.cfg_addr = '0;
        bus.cfg_sel = '0; bus.cfg_commit = 1'b0; bus.err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data_out", bus.data_out, 64'd0);
        chk("rst_sel_err", 64'(bus.sel_err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Identity mapping, lanes 6/7 wrap to inputs 0/1
        cycle(1, pat(8'h10));
        idle(4);
        chk("t1_lane5", 64'(bus.data_out[5*DW +: DW]), 64'h15);
        chk("t1_lane7", 64'(bus.data_out[7*DW +: DW]), 64'h11);

        // Route input 5 to output 2
        cycle(0, '0, 1, 4'd2, 3'd5);
        d = pat(8'h20);
        d[5*DW +: DW] = 8'hA5;
        cycle(1, d);
        idle(4);
        chk("t2_lane2", 64'(bus.data_out[2*DW +: DW]), 64'hA5);

        // Config write coincident with a beat: that beat sees the old select
        cycle(1, pat(8'h30), 1, 4'd0, 3'd5);
        cycle(1, pat(8'h40));
        idle(4);
        chk("t3_lane0_new", 64'(bus.data_out[0 +: DW]), 64'h45);
        cycle(0, '0, 1, 4'd0, 3'd0);
        cycle(0, '0, 1, 4'd2, 3'd2);

        // Illegal select on lane 3
        cycle(0, '0, 1, 4'd3, 3'd6);
        idle(4);
        chk("t4_no_err_idle", 64'(bus.sel_err), 64'd0);
        cycle(1, pat(8'h50));
        idle(4);
        chk("t4_err_set", 64'(bus.sel_err), 64'd1);
        chk("t4_lane3_zero", 64'(bus.data_out[3*DW +: DW]), 64'h00);
        chk("t4_lane4_legal", 64'(bus.data_out[4*DW +: DW]), 64'h54);
        cycle(0, '0, 0, '0, '0, 0, 1);
        chk("t4_err_clr", 64'(bus.sel_err), 64'd0);
        cycle(1, pat(8'h60));
        idle(4);
        chk("t4_err_set2", 64'(bus.sel_err), 64'd1);
        cycle(1, pat(8'h70));
        cycle(0, '0);
        cycle(0, '0, 0, '0, '0, 0, 1);   // err_clr on the edge the bad beat enters S3
        chk("t4_clr_vs_new_err", 64'(bus.sel_err), 64'd1);
        cycle(0, '0, 0, '0, '0, 0, 1);
        chk("t4_err_clr2", 64'(bus.sel_err), 64'd0);
        cycle(0, '0, 1, 4'd3, 3'd3);

        // Out-of-range cfg_addr ignored
        cycle(0, '0, 1, 4'd9, 3'd4);
        cycle(0, '0, 1, 4'd15, 3'd4);
        cycle(1, pat(8'h80));
        idle(4);
        chk("t5_lane1", 64'(bus.data_out[1*DW +: DW]), 64'h81);
        chk("t5_lane7", 64'(bus.data_out[7*DW +: DW]), 64'h81);

`ifdef XBAR_SHADOW_EN
        // Shadow swap of lanes 0/1, visible only after commit
        cycle(0, '0, 1, 4'd0, 3'd1);
        cycle(0, '0, 1, 4'd1, 3'd0);
        cycle(1, pat(8'h90));
        cycle(1, pat(8'hA0), 0, '0, '0, 1);
        cycle(1, pat(8'hB0));
        idle(4);
        chk("t6_lane0_swap", 64'(bus.data_out[0 +: DW]), 64'hB1);
        chk("t6_lane1_swap", 64'(bus.data_out[1*DW +: DW]), 64'hB0);
`else
        // Direct writes take effect at once; cfg_commit has no effect
        cycle(0, '0, 1, 4'd0, 3'd1, 1);
        cycle(1, pat(8'h90));
        cycle(0, '0, 1, 4'd1, 3'd0);
        cycle(1, pat(8'hA0));
        idle(4);
        chk("t6_lane0_swap", 64'(bus.data_out[0 +: DW]), 64'hA1);
        chk("t6_lane1_swap", 64'(bus.data_out[1*DW +: DW]), 64'hA0);
`endif

        // Reset mid-stream: in-flight beats dropped, identity restored
        cycle(1, pat(8'hC0));
        cycle(1, pat(8'hD0));
        cycle(1, pat(8'hE0));
        rst = 1'b1;
        q.delete();
        model_reset();
        @(negedge clk);
        chk("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_data_out", bus.data_out, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(1, pat(8'hF0));
        idle(4);
        chk("t6_identity_lane0", 64'(bus.data_out[0 +: DW]), 64'hF0);
        chk("t6_identity_lane1", 64'(bus.data_out[1*DW +: DW]), 64'hF1);

        idle(2);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
